execute_cycle: RTL and testbench
================================

# execute_cycle

Execute stage of the 5-stage RISC-V pipeline, directly upstream of the memory stage. It resolves the forwarded operands, runs the ALU, and decides branches and jumps. It also computes the branch/jump target. It registers control, ALU result, store data, destination register and PC+4 into the EX/MEM pipeline register that feeds the memory stage.

## Interface
Parameters: none; datapath fixed at 32 bits, register index 5 bits.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; clears EX/MEM register
- HoldM  input  1  1 = EX/MEM register keeps its value (downstream stall)
- RegWriteE, MemWriteE, ResultSrcE  input  1 each  control from decode, passed to M
- ALUSrcE  input  1  0 = ALU B from forwarded rs2, 1 = Imm_Ext_E
- BranchE  input  1  conditional branch (beq semantics)
- JumpE  input  1  unconditional jump
- ALUControlE  input  3  ALU operation select
- RD1_E, RD2_E  input  32  register-file operands
- Imm_Ext_E  input  32  sign-extended immediate
- PCE, PCPlus4E  input  32  instruction PC and PC+4
- RD_E  input  5  destination register
- ForwardA_E, ForwardB_E  input  2  operand forwarding selects from hazard unit
- ResultW  input  32  writeback-stage result for forwarding
- PCSrcE  output  1  combinational; 1 = fetch must take PCTargetE
- PCTargetE  output  32  combinational; PCE + Imm_Ext_E
- RegWriteM, MemWriteM, ResultSrcM  output  1 each  registered control
- RD_M  output  5  registered destination register
- ALU_ResultM, WriteDataM, PCPlus4M  output  32  registered ALU result, store data, PC+4

## Operation
- Forwarding for operand A and for the rs2 path uses the same encoding:
  - 00 selects RD1_E / RD2_E.
  - 01 selects ResultW.
  - 10 selects ALU_ResultM, the current registered output.
  - 11 is treated as 00.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded rs2. WriteDataM captures the forwarded rs2, never the immediate.
- ALUControlE encoding:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 0/1)
  - 110 SLTU (unsigned, result 0/1)
  - 111 SLL by SrcB[4:0]
- ADD, SUB and PCTargetE wrap modulo 2^32; carry and overflow are discarded.
- ZeroE = (ALU result == 0).
- PCSrcE = JumpE | (BranchE & ZeroE).
- The instruction in EX always proceeds to M regardless of PCSrcE; a jump still writes PC+4. Flushing younger instructions is the hazard unit's job.
- EX/MEM register, evaluated on the rising clk edge with priority reset > HoldM > load:
  - reset == 0: all registered outputs clear to 0.
  - HoldM == 1: all registered outputs unchanged.
  - otherwise: load the current EX values.

## Timing
- Registered outputs have 1-cycle latency: EX values at edge N appear on the M outputs after edge N.
- PCSrcE and PCTargetE have 0-cycle latency; they are purely combinational from the current inputs, including during reset.
- Reset value of every registered output is 0: RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M.
- Reset asserted mid-stream clears the register at the next edge, even when HoldM = 1.
- During HoldM the value forwarded by select 10 stays the held ALU_ResultM.
- Simultaneous ForwardA_E = 10 and ForwardB_E = 01 is legal; each operand is muxed independently.
- First edge after reset deasserts: normal load.

## Test plan
- Reset, then ADD: assert reset = 0 for 2 cycles; all M outputs are 0. Then RD1_E = 5, RD2_E = 7, ALUControlE = 000, RD_E = 3, RegWriteE = 1 -> after 1 edge ALU_ResultM = 12, RD_M = 3, RegWriteM = 1.
- Arithmetic and compare edges:
  - SUB 0 − 1 -> ALU_ResultM = 0xFFFFFFFF.
  - SLT with 0xFFFFFFFF vs 1 -> 1.
  - SLTU with the same operands -> 0.
  - SLL 1 by SrcB = 0x21 -> 2 (only the low 5 bits are used).
- Forwarding:
  - Previous result ALU_ResultM = 0x10, ForwardA_E = 10, RD2_E = 1, ADD -> ALU_ResultM = 0x11.
  - ResultW = 0x20, ForwardB_E = 01, ALUSrcE = 0, MemWriteE = 1 -> WriteDataM = 0x20.
  - ForwardA_E = 11 uses RD1_E.
- Branch and jump:
  - BranchE = 1, RD1_E = RD2_E = 9, SUB -> PCSrcE = 1 in the same cycle; PCE = 0x100, Imm_Ext_E = 0xFFFFFFF0 gives PCTargetE = 0xF0.
  - Unequal operands -> PCSrcE = 0.
  - JumpE = 1 -> PCSrcE = 1 and PCPlus4M = PCPlus4E after the edge.
- Hold and reset priority:
  - HoldM = 1 for 3 cycles with changing inputs -> M outputs frozen.
  - Reset = 0 while HoldM = 1 -> outputs 0 at the next edge.
  - Release both -> the next edge loads the current inputs.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump decision and target,
// and the EX/MEM pipeline register feeding the memory stage.
module execute_cycle (
    input  logic        clk,
    input  logic        reset,
    input  logic        HoldM,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        ALUSrcE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALU_ResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    // Select 11 is unused by the hazard unit and falls back to the register file.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf_val,
                                            input logic [31:0] wb_val,
                                            input logic [31:0] mem_val);
        case (sel)
            2'b01:   fwd_mux = wb_val;
            2'b10:   fwd_mux = mem_val;
            default: fwd_mux = rf_val;
        endcase
    endfunction

    function automatic logic [31:0] alu_op(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  alu_op = a + b;
            3'b001:  alu_op = a - b;
            3'b010:  alu_op = a & b;
            3'b011:  alu_op = a | b;
            3'b100:  alu_op = a ^ b;
            3'b101:  alu_op = {31'b0, (sa < sb)};
            3'b110:  alu_op = {31'b0, (a < b)};
            default: alu_op = a << b[4:0];
        endcase
    endfunction

    logic        regwrite_q, regwrite_d;
    logic        memwrite_q, memwrite_d;
    logic        resultsrc_q, resultsrc_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    logic [31:0] src_a;
    logic [31:0] rs2_fwd;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;

    // EX stage: forwarding, ALU, branch resolution
    assign src_a      = fwd_mux(ForwardA_E, RD1_E, ResultW, alu_result_q);
    assign rs2_fwd    = fwd_mux(ForwardB_E, RD2_E, ResultW, alu_result_q);
    assign src_b      = ALUSrcE ? Imm_Ext_E : rs2_fwd;
    assign alu_result = alu_op(ALUControlE, src_a, src_b);
    assign zero       = (alu_result == 32'd0);

    assign PCSrcE    = JumpE | (BranchE & zero);
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        regwrite_d   = regwrite_q;
        memwrite_d   = memwrite_q;
        resultsrc_d  = resultsrc_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        if (!reset) begin
            regwrite_d   = 1'b0;
            memwrite_d   = 1'b0;
            resultsrc_d  = 1'b0;
            rd_d         = 5'd0;
            alu_result_d = 32'd0;
            write_data_d = 32'd0;
            pc_plus4_d   = 32'd0;
        end else if (!HoldM) begin
            regwrite_d   = RegWriteE;
            memwrite_d   = MemWriteE;
            resultsrc_d  = ResultSrcE;
            rd_d         = RD_E;
            alu_result_d = alu_result;
            write_data_d = rs2_fwd;
            pc_plus4_d   = PCPlus4E;
        end
    end

    // EX/MEM boundary
    always_ff @(posedge clk) begin
        regwrite_q   <= regwrite_d;
        memwrite_q   <= memwrite_d;
        resultsrc_q  <= resultsrc_d;
        rd_q         <= rd_d;
        alu_result_q <= alu_result_d;
        write_data_q <= write_data_d;
        pc_plus4_q   <= pc_plus4_d;
    end

    assign RegWriteM   = regwrite_q;
    assign MemWriteM   = memwrite_q;
    assign ResultSrcM  = resultsrc_q;
    assign RD_M        = rd_q;
    assign ALU_ResultM = alu_result_q;
    assign WriteDataM  = write_data_q;
    assign PCPlus4M    = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the execute stage.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        HoldM;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    // reference model of the memory-stage register contents
    logic        m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    execute_cycle dut (
        .clk(clk), .reset(reset), .HoldM(HoldM),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return a * (32'd1 << sh);
        endcase
    endfunction

    // One EX cycle: check combinational outputs, clock, then check M outputs.
    task automatic cycle();
        logic [31:0] a, b2, b, res, tgt;
        logic        take;
        #2;
        a    = ref_operand(ForwardA_E, RD1_E);
        b2   = ref_operand(ForwardB_E, RD2_E);
        b    = ALUSrcE ? Imm_Ext_E : b2;
        res  = ref_alu(ALUControlE, a, b);
        take = JumpE || (BranchE && res == 32'd0);
        tgt  = PCE + Imm_Ext_E;
        check("PCSrcE", 32'(PCSrcE), 32'(take));
        check("PCTargetE", PCTargetE, tgt);
        @(posedge clk);
        if (!reset) begin
            {m_rw, m_mw, m_rs} = 3'b000;
            m_rd = 5'd0; m_alu = 32'd0; m_wd = 32'd0; m_pc4 = 32'd0;
        end else if (!HoldM) begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
            m_rd = RD_E; m_alu = res; m_wd = b2; m_pc4 = PCPlus4E;
        end
        #1;
        check("RegWriteM", 32'(RegWriteM), 32'(m_rw));
        check("MemWriteM", 32'(MemWriteM), 32'(m_mw));
        check("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
        check("RD_M", 32'(RD_M), 32'(m_rd));
        check("ALU_ResultM", ALU_ResultM, m_alu);
        check("WriteDataM", WriteDataM, m_wd);
        check("PCPlus4M", PCPlus4M, m_pc4);
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
        BranchE = 0; JumpE = 0; ALUControlE = 3'd0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    endtask

    task automatic randomize_inputs();
        logic [31:0] r;
        r = $urandom();
        RegWriteE = r[0]; MemWriteE = r[1]; ResultSrcE = r[2]; ALUSrcE = r[3];
        BranchE = r[4]; JumpE = (r[7:5] == 3'd0); ALUControlE = r[10:8];
        RD_E = r[15:11]; ForwardA_E = r[17:16]; ForwardB_E = r[19:18];
        RD1_E = $urandom(); ResultW = $urandom(); Imm_Ext_E = $urandom();
        PCE = $urandom(); PCPlus4E = PCE + 32'd4;
        RD2_E = r[21] ? RD1_E : $urandom();
        if (r[23:22] == 2'd0) RD1_E = {28'd0, r[27:24]};
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] r;
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
        clear_inputs();
        reset = 0; HoldM = 0;
        @(posedge clk); #1;
        {m_rw, m_mw, m_rs} = 3'b000;
        cycle();
        cycle();
        check("reset_alu", ALU_ResultM, 32'd0);
        check("reset_rw", 32'(RegWriteM), 32'd0);

        reset = 1;
        RD1_E = 5; RD2_E = 7; ALUControlE = 3'd0; RD_E = 3; RegWriteE = 1;
        cycle();
        check("add_res", ALU_ResultM, 32'd12);
        check("add_rd", 32'(RD_M), 32'd3);
        check("add_rw", 32'(RegWriteM), 32'd1);

        RD1_E = 0; RD2_E = 1; ALUControlE = 3'd1; cycle();
        check("sub_wrap", ALU_ResultM, 32'hFFFF_FFFF);
        RD1_E = 32'hFFFF_FFFF; RD2_E = 1; ALUControlE = 3'd5; cycle();
        check("slt", ALU_ResultM, 32'd1);
        ALUControlE = 3'd6; cycle();
        check("sltu", ALU_ResultM, 32'd0);
        RD1_E = 1; ALUSrcE = 1; Imm_Ext_E = 32'h21; ALUControlE = 3'd7; cycle();
        check("sll_low5", ALU_ResultM, 32'd2);

        ALUSrcE = 0; RD1_E = 32'h10; RD2_E = 0; ALUControlE = 3'd0; cycle();
        RD1_E = 32'h55; RD2_E = 1; ForwardA_E = 2'b10; cycle();
        check("fwdA_mem", ALU_ResultM, 32'h11);
        ForwardA_E = 0; ResultW = 32'h20; ForwardB_E = 2'b01; MemWriteE = 1; RD2_E = 32'h99;
        cycle();
        check("fwdB_wb_store", WriteDataM, 32'h20);
        check("fwdB_memwrite", 32'(MemWriteM), 32'd1);
        ForwardB_E = 0; MemWriteE = 0; ForwardA_E = 2'b11; RD1_E = 7; RD2_E = 1; cycle();
        check("fwdA_11", ALU_ResultM, 32'd8);

        ForwardA_E = 0; BranchE = 1; RD1_E = 9; RD2_E = 9; ALUControlE = 3'd1;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
        #1;
        check("beq_taken", 32'(PCSrcE), 32'd1);
        check("beq_target", PCTargetE, 32'hF0);
        cycle();
        RD2_E = 8; #1;
        check("beq_not_taken", 32'(PCSrcE), 32'd0);
        cycle();
        BranchE = 0; JumpE = 1; PCPlus4E = 32'h1234; #1;
        check("jump_taken", 32'(PCSrcE), 32'd1);
        cycle();
        check("jump_pc4", PCPlus4M, 32'h1234);
        JumpE = 0;

        held = ALU_ResultM;
        HoldM = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            cycle();
        end
        check("hold_frozen", ALU_ResultM, held);
        check("hold_pc4", PCPlus4M, 32'h1234);
        reset = 0; cycle();
        check("reset_over_hold", ALU_ResultM, 32'd0);
        check("reset_over_hold_pc4", PCPlus4M, 32'd0);
        reset = 1; HoldM = 0; clear_inputs();
        RD1_E = 32'h40; RD2_E = 2; ALUControlE = 3'd3; PCPlus4E = 32'h88; cycle();
        check("release_load", ALU_ResultM, 32'h42);
        check("release_pc4", PCPlus4M, 32'h88);

        for (int i = 0; i < 500; i++) begin
            r = $urandom();
            randomize_inputs();
            reset = (r[4:0] != 5'd0);
            HoldM = (r[7:5] == 3'd0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
